shift_reg_piso: RTL and testbench
=================================

SHIFT_REG_PISO -- requirements
Module: shift_reg_piso

Interface
REQ-001 Parameter WIDTH, default 4: number of data bits per word; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 load_valid  input  1  parallel word offered on parallel_data_in.
REQ-005 load_ready  output  1  block can accept a word this cycle.
REQ-006 parallel_data_in  input  [0:WIDTH-1]  word to serialise; index 0 is transmitted first.
REQ-007 serial_data_out  output  1  serial bit stream, one bit per clk.
REQ-008 serial_valid  output  1  serial_data_out carries a frame bit this cycle.
REQ-009 frame_done  output  1  one-cycle pulse coincident with the last bit of a frame.

Function
REQ-010 Handshake: a word is accepted on a rising edge where load_valid=1 and load_ready=1; no other condition loads data.
REQ-011 FSM states: IDLE and SHIFT; IDLE->SHIFT on accept; SHIFT->IDLE after the last frame bit unless a new word is accepted on that same edge (SHIFT->SHIFT).
REQ-012 Latency: first bit (index 0) appears on serial_data_out with serial_valid=1 in the cycle following the accepting edge.
REQ-013 Bits index 0..WIDTH-1 are driven in order, one per cycle, with serial_valid=1 for every frame bit.
REQ-014 A bit counter of ceil(log2(WIDTH+1)) bits tracks position; it restarts at 0 on every accept.
REQ-015 load_ready=1 in IDLE and during the last bit cycle of a frame; 0 during all other SHIFT cycles.
REQ-016 Back-to-back: an accept during the last bit cycle yields the next word's bit 0 on the immediately following cycle; no gap cycle.
REQ-017 parallel_data_in is captured into an internal register at accept; later changes on the input do not affect the frame in flight.
REQ-018 load_valid while load_ready=0 is ignored; the offered word is not queued.
REQ-019 In IDLE: serial_data_out=0, serial_valid=0, frame_done=0.
REQ-020 frame_done=1 only in the last bit cycle of each frame, including back-to-back frames.

Reset
REQ-021 On a rising edge with reset=0: state=IDLE, counter=0, shift register=0, serial_data_out=0, serial_valid=0, frame_done=0, load_ready=1.
REQ-022 Reset during SHIFT aborts the frame; the remaining bits are never sent and no frame_done is issued.
REQ-023 No word is accepted on an edge where reset=0, regardless of load_valid.
REQ-024 Normal operation resumes on the first edge with reset=1; a word may be accepted on that edge.

Configuration
REQ-025 Macro PISO_PARITY_EN: when defined, each frame is WIDTH+1 bits; the extra final bit is even parity (XOR of all WIDTH data bits) with serial_valid=1.
REQ-026 With PISO_PARITY_EN defined, frame_done and the load_ready window of REQ-015 move to the parity-bit cycle.
REQ-027 Without PISO_PARITY_EN, frames are exactly WIDTH bits; no parity logic is present.

Verification
REQ-028 WIDTH=4, reset released, offer 4'b1010 (index0=1) -> serial_data_out 1,0,1,0 on the 4 cycles after accept, serial_valid=1 throughout, frame_done on the 4th bit.
REQ-029 Two words 1000 then 0111, second offered during the last bit of the first -> contiguous stream 1,0,0,0,0,1,1,1, two frame_done pulses 4 cycles apart.
REQ-030 load_valid=1 with 1111 during bit 2 of frame 1010 -> ignored, load_ready=0, stream unchanged.
REQ-031 Reset=0 asserted at bit 2 of frame 1100 -> next cycle all outputs 0, load_ready=1, no frame_done; 0110 accepted after release sends 0,1,1,0.
REQ-032 PISO_PARITY_EN defined, words 1011 and 1001 -> streams 1,0,1,1,1 and 1,0,0,1,0; frame_done on the 5th bit.
REQ-033 parallel_data_in changed from 0101 to 1111 one cycle after accept -> stream remains 0,1,0,1.

Source files
------------

// File: rtl/shift_reg_piso.sv
// Parallel-in / serial-out shifter with a valid/ready load handshake; index 0 is sent first.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module shift_reg_piso #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [0:WIDTH-1] parallel_data_in,
   output logic             serial_data_out,
   output logic             serial_valid,
   output logic             frame_done
);

   localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_r, state_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s, nxt_idx_s;
   logic [0:WIDTH-1]   shreg_r, shreg_s;
   logic               sdo_r, sdo_s;
   logic               sv_r, sv_s;
   logic               fd_r, fd_s;
   logic               ready_r, ready_s;
   logic               accept_s;

`ifdef PISO_PARITY_EN
   logic               par_r, par_s;

   function automatic logic even_parity(input logic [0:WIDTH-1] d);
      return ^d;
   endfunction
`endif

   assign accept_s = load_valid & ready_r;

   // Next-state and next-output logic; every output is registered from these values.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      shreg_s   = shreg_r;
      sdo_s     = 1'b0;
      sv_s      = 1'b0;
      fd_s      = 1'b0;
      ready_s   = 1'b1;
      nxt_idx_s = cnt_r + CNT_W'(1);
`ifdef PISO_PARITY_EN
      par_s     = par_r;
`endif
      if (accept_s) begin
         // Bit 0 goes straight to the output register; the rest wait in shreg.
         state_s = SHIFT;
         cnt_s   = {CNT_W{1'b0}};
         shreg_s = {parallel_data_in[1:WIDTH-1], 1'b0};
         sdo_s   = parallel_data_in[0];
         sv_s    = 1'b1;
         ready_s = 1'b0;
`ifdef PISO_PARITY_EN
         par_s   = even_parity(parallel_data_in);
`endif
      end else begin
         case (state_r)
            SHIFT: begin
               if (cnt_r != LAST_IDX) begin
                  cnt_s   = nxt_idx_s;
                  shreg_s = {shreg_r[1:WIDTH-1], 1'b0};
                  sdo_s   = shreg_r[0];
`ifdef PISO_PARITY_EN
                  if (nxt_idx_s == CNT_W'(WIDTH)) begin
                     sdo_s = par_r;
                  end else begin
                     sdo_s = shreg_r[0];
                  end
`endif
                  sv_s    = 1'b1;
                  fd_s    = (nxt_idx_s == LAST_IDX);
                  ready_s = (nxt_idx_s == LAST_IDX);
               end else begin
                  state_s = IDLE;
                  cnt_s   = {CNT_W{1'b0}};
                  shreg_s = {WIDTH{1'b0}};
               end
            end
            IDLE: begin
               state_s = IDLE;
            end
            default: begin
               state_s = IDLE;
               cnt_s   = {CNT_W{1'b0}};
               shreg_s = {WIDTH{1'b0}};
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         shreg_r <= {WIDTH{1'b0}};
         sdo_r   <= 1'b0;
         sv_r    <= 1'b0;
         fd_r    <= 1'b0;
         ready_r <= 1'b1;
`ifdef PISO_PARITY_EN
         par_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         shreg_r <= shreg_s;
         sdo_r   <= sdo_s;
         sv_r    <= sv_s;
         fd_r    <= fd_s;
         ready_r <= ready_s;
`ifdef PISO_PARITY_EN
         par_r   <= par_s;
`endif
      end
   end

   assign serial_data_out = sdo_r;
   assign serial_valid    = sv_r;
   assign frame_done      = fd_r;
   assign load_ready      = ready_r;

endmodule

// File: tb/tb_shift_reg_piso.sv
// Directed bench for shift_reg_piso (WIDTH=4); expected vectors are {serial_data_out,
// serial_valid, frame_done, load_ready}, checked 1 time unit after each rising edge.
module tb_shift_reg_piso;

   logic       clk = 1'b0;
   logic       reset;
   logic       load_valid;
   logic       load_ready;
   logic [0:3] parallel_data_in;
   logic       serial_data_out;
   logic       serial_valid;
   logic       frame_done;

   int n_vec = 0;
   int n_err = 0;

   shift_reg_piso #(.WIDTH(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .load_valid       (load_valid),
      .load_ready       (load_ready),
      .parallel_data_in (parallel_data_in),
      .serial_data_out  (serial_data_out),
      .serial_valid     (serial_valid),
      .frame_done       (frame_done)
   );

   always #5 clk = ~clk;

   task automatic cyc(input string tag, input logic [3:0] exp);
      logic [3:0] obs;
      @(posedge clk);
      #1;
      obs = {serial_data_out, serial_valid, frame_done, load_ready};
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      reset            = 1'b0;
      load_valid       = 1'b1;
      parallel_data_in = 4'b1111;
      // load_valid during reset must not be accepted
      cyc("rst0", 4'b0001);
      cyc("rst1", 4'b0001);

`ifdef PISO_PARITY_EN
      // 1011 (parity 1) accepted on the release edge, then 1001 (parity 0) back-to-back
      reset = 1'b1; load_valid = 1'b1; parallel_data_in = 4'b1011;
      cyc("p1011_b0", 4'b1100);
      load_valid = 1'b0; parallel_data_in = 4'b0000;
      cyc("p1011_b1", 4'b0100);
      cyc("p1011_b2", 4'b1100);
      cyc("p1011_b3", 4'b1100);
      cyc("p1011_par", 4'b1111);
      load_valid = 1'b1; parallel_data_in = 4'b1001;
      cyc("p1001_b0", 4'b1100);
      load_valid = 1'b0;
      cyc("p1001_b1", 4'b0100);
      cyc("p1001_b2", 4'b0100);
      cyc("p1001_b3", 4'b1100);
      cyc("p1001_par", 4'b0111);
      cyc("p_idle0", 4'b0001);
      // reset aborts frame 1100 at bit 2
      load_valid = 1'b1; parallel_data_in = 4'b1100;
      cyc("pab_b0", 4'b1100);
      load_valid = 1'b0;
      cyc("pab_b1", 4'b1100);
      cyc("pab_b2", 4'b0100);
      reset = 1'b0;
      cyc("pab_rst", 4'b0001);
      reset = 1'b1;
      cyc("pab_idle", 4'b0001);
      // input changed after accept does not affect 0101 (parity 0)
      load_valid = 1'b1; parallel_data_in = 4'b0101;
      cyc("p0101_b0", 4'b0100);
      load_valid = 1'b0; parallel_data_in = 4'b1111;
      cyc("p0101_b1", 4'b1100);
      cyc("p0101_b2", 4'b0100);
      cyc("p0101_b3", 4'b1100);
      cyc("p0101_par", 4'b0111);
      cyc("p_idle1", 4'b0001);
`else
      // 1010 accepted on the release edge
      reset = 1'b1; load_valid = 1'b1; parallel_data_in = 4'b1010;
      cyc("f1010_b0", 4'b1100);
      load_valid = 1'b0; parallel_data_in = 4'b0000;
      cyc("f1010_b1", 4'b0100);
      cyc("f1010_b2", 4'b1100);
      cyc("f1010_b3", 4'b0111);
      cyc("idle0", 4'b0001);

      // back-to-back 1000 then 0111
      load_valid = 1'b1; parallel_data_in = 4'b1000;
      cyc("f1000_b0", 4'b1100);
      load_valid = 1'b0;
      cyc("f1000_b1", 4'b0100);
      cyc("f1000_b2", 4'b0100);
      cyc("f1000_b3", 4'b0111);
      load_valid = 1'b1; parallel_data_in = 4'b0111;
      cyc("f0111_b0", 4'b0100);
      load_valid = 1'b0;
      cyc("f0111_b1", 4'b1100);
      cyc("f0111_b2", 4'b1100);
      cyc("f0111_b3", 4'b1111);
      cyc("idle1", 4'b0001);

      // 1111 offered while busy is dropped, not queued
      load_valid = 1'b1; parallel_data_in = 4'b1010;
      cyc("ign_b0", 4'b1100);
      load_valid = 1'b0;
      cyc("ign_b1", 4'b0100);
      cyc("ign_b2", 4'b1100);
      load_valid = 1'b1; parallel_data_in = 4'b1111;
      cyc("ign_b3", 4'b0111);
      load_valid = 1'b0;
      cyc("ign_idle0", 4'b0001);
      cyc("ign_idle1", 4'b0001);

      // reset at bit 2 of 1100 aborts the frame, then 0110 is sent
      load_valid = 1'b1; parallel_data_in = 4'b1100;
      cyc("ab_b0", 4'b1100);
      load_valid = 1'b0;
      cyc("ab_b1", 4'b1100);
      cyc("ab_b2", 4'b0100);
      reset = 1'b0;
      cyc("ab_rst", 4'b0001);
      reset = 1'b1;
      cyc("ab_idle", 4'b0001);
      load_valid = 1'b1; parallel_data_in = 4'b0110;
      cyc("f0110_b0", 4'b0100);
      load_valid = 1'b0;
      cyc("f0110_b1", 4'b1100);
      cyc("f0110_b2", 4'b1100);
      cyc("f0110_b3", 4'b0111);
      cyc("idle2", 4'b0001);

      // input changed one cycle after accept does not affect 0101
      load_valid = 1'b1; parallel_data_in = 4'b0101;
      cyc("f0101_b0", 4'b0100);
      load_valid = 1'b0; parallel_data_in = 4'b1111;
      cyc("f0101_b1", 4'b1100);
      cyc("f0101_b2", 4'b0100);
      cyc("f0101_b3", 4'b1111);
      cyc("idle3", 4'b0001);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
